// File: rtl/pool_stream_unit_pkg.sv
// Shared encodings for the pool stream slice: FSM state codes and pooling-mode values.
// Imported by pool_stream_unit and pool_window_reduce.
package pool_stream_unit_pkg;

    typedef logic [1:0] pool_state_t;

    localparam pool_state_t ST_IDLE  = 2'd0;
    localparam pool_state_t ST_RUN   = 2'd1;
    localparam pool_state_t ST_FLUSH = 2'd2;
    localparam pool_state_t ST_DONE  = 2'd3;

    localparam logic POOL_AVG = 1'b0;
    localparam logic POOL_MAX = 1'b1;

endpackage

// File: rtl/pool_window_reduce.sv
// Combinational 2x2 window reduction: floor average, or signed max when POOL_STREAM_MAX_EN is defined.
// Without POOL_STREAM_MAX_EN the comparator tree is not built and mode is ignored.
module pool_window_reduce
    import pool_stream_unit_pkg::*;
#(
    parameter int DATA_W = 32
)(
    input  logic                     mode,
    input  logic signed [DATA_W-1:0] px0,
    input  logic signed [DATA_W-1:0] px1,
    input  logic signed [DATA_W-1:0] px2,
    input  logic signed [DATA_W-1:0] px3,
    output logic signed [DATA_W-1:0] result
);

    logic [DATA_W+1:0] sum_s;
    logic [DATA_W-1:0] avg_s;
    logic [1:0]        unused_sum_lsb_s;

    // Two guard bits keep the four-way sum exact; dropping the low two bits is a floor divide by 4.
    assign sum_s = {{2{px0[DATA_W-1]}}, px0} + {{2{px1[DATA_W-1]}}, px1}
                 + {{2{px2[DATA_W-1]}}, px2} + {{2{px3[DATA_W-1]}}, px3};
    assign avg_s            = sum_s[DATA_W+1:2];
    assign unused_sum_lsb_s = sum_s[1:0];

`ifdef POOL_STREAM_MAX_EN
    logic signed [DATA_W-1:0] max01_s;
    logic signed [DATA_W-1:0] max23_s;
    logic signed [DATA_W-1:0] max_s;

    assign max01_s = (px0 > px1) ? px0 : px1;
    assign max23_s = (px2 > px3) ? px2 : px3;
    assign max_s   = (max01_s > max23_s) ? max01_s : max23_s;
    assign result  = (mode == POOL_MAX) ? max_s : avg_s;
`else
    logic unused_mode_s;

    assign unused_mode_s = mode;
    assign result        = avg_s;
`endif

endmodule

// File: rtl/pool_stream_unit.sv
// Streaming 2x2/stride-2 pooling over a raster-order, channel-interleaved feature map.
// Optional max mode is enabled with the POOL_STREAM_MAX_EN macro (average only otherwise).
module pool_stream_unit
    import pool_stream_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int FM_W   = 6,
    parameter int FM_H   = 6,
    parameter int CH     = 1
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam int COL_W = (FM_W > 2) ? $clog2(FM_W) : 1;
    localparam int ROW_W = (FM_H > 2) ? $clog2(FM_H) : 1;
    localparam int CH_W  = (CH > 1) ? $clog2(CH) : 1;
    localparam int LB_N  = FM_W * CH;
    localparam int LB_W  = (LB_N > 2) ? $clog2(LB_N) : 1;

    if ((FM_W % 2) != 0 || FM_W < 2 || (FM_H % 2) != 0 || FM_H < 2 || CH < 1) begin : g_bad_geometry
        $error("pool_stream_unit: FM_W and FM_H must be even and >= 2, CH >= 1");
    end

    pool_state_t       state_q, state_d;
    logic              mode_q, mode_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] lb_q   [LB_N];
    logic [DATA_W-1:0] hold_q [CH];

    logic              in_xfer_s, out_xfer_s;
    logic              last_ch_s, last_col_s, last_row_s, frame_last_s;
    logic [LB_W-1:0]   lb_idx_s, lb_pair_idx_s;
    logic [DATA_W-1:0] red_s;

    assign in_ready     = (state_q == ST_RUN) && (!out_valid_q || out_ready);
    assign in_xfer_s    = in_valid && in_ready;
    assign out_xfer_s   = out_valid_q && out_ready;
    assign last_ch_s    = (ch_q == CH_W'(CH - 1));
    assign last_col_s   = (col_q == COL_W'(FM_W - 1));
    assign last_row_s   = (row_q == ROW_W'(FM_H - 1));
    assign frame_last_s = last_ch_s && last_col_s && last_row_s;
    // Line-buffer slot of this pixel and of its left neighbour in the same channel.
    assign lb_idx_s      = LB_W'(int'(col_q) * CH + int'(ch_q));
    assign lb_pair_idx_s = lb_idx_s - LB_W'(CH);

    pool_window_reduce #(.DATA_W(DATA_W)) u_reduce (
        .mode   (mode_q),
        .px0    (lb_q[lb_pair_idx_s]),
        .px1    (lb_q[lb_idx_s]),
        .px2    (hold_q[ch_q]),
        .px3    (in_data),
        .result (red_s)
    );

    // Next-state for FSM, raster counters and the single output register.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        col_d       = col_q;
        row_d       = row_q;
        ch_d        = ch_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        if (out_xfer_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    mode_d  = mode;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (in_xfer_s && frame_last_s) begin
                    state_d = ST_FLUSH;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (out_xfer_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (in_xfer_s) begin
            if (last_ch_s) begin
                ch_d = {CH_W{1'b0}};
                if (last_col_s) begin
                    col_d = {COL_W{1'b0}};
                    row_d = last_row_s ? {ROW_W{1'b0}} : row_q + ROW_W'(1);
                end else begin
                    col_d = col_q + COL_W'(1);
                end
            end else begin
                ch_d = ch_q + CH_W'(1);
            end
            // in_ready guarantees the output register is free (or draining) here.
            if (row_q[0] && col_q[0]) begin
                out_data_d  = red_s;
                out_valid_d = 1'b1;
            end else begin
                out_data_d = out_data_q;
            end
        end else begin
            ch_d = ch_q;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mode_q      <= POOL_AVG;
            col_q       <= {COL_W{1'b0}};
            row_q       <= {ROW_W{1'b0}};
            ch_q        <= {CH_W{1'b0}};
            out_data_q  <= {DATA_W{1'b0}};
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            col_q       <= col_d;
            row_q       <= row_d;
            ch_q        <= ch_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Even rows fill the line buffer; odd-row even-column pixels wait in the per-channel hold registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LB_N; i++) begin
                lb_q[i] <= {DATA_W{1'b0}};
            end
            for (int j = 0; j < CH; j++) begin
                hold_q[j] <= {DATA_W{1'b0}};
            end
        end else if (in_xfer_s) begin
            if (!row_q[0]) begin
                lb_q[lb_idx_s] <= in_data;
            end else if (!col_q[0]) begin
                hold_q[ch_q] <= in_data;
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q == ST_RUN) || (state_q == ST_FLUSH);
    assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_pool_stream_unit.sv
// Scoreboard bench for pool_stream_unit: a 4x4/CH=1 instance and a 2x2/CH=2 instance.
// Max-mode expectations follow POOL_STREAM_MAX_EN.
module tb_pool_stream_unit;

    typedef int frame_t [16];
    typedef int exp_t   [4];

    logic        clk = 1'b0;
    logic        rst;
    logic        start0, mode0, in_valid0, out_ready0;
    logic [31:0] in_data0;
    logic        in_ready0, out_valid0, busy0, done0;
    logic [31:0] out_data0;
    logic        start1, mode1, in_valid1, out_ready1;
    logic [31:0] in_data1;
    logic        in_ready1, out_valid1, busy1, done1;
    logic [31:0] out_data1;

    int vectors     = 0;
    int miscompares = 0;
    int out_cnt0    = 0;
    int out_cnt1    = 0;
    int q0[$];
    int q1[$];

    always #5 clk = ~clk;

    pool_stream_unit #(.DATA_W(32), .FM_W(4), .FM_H(4), .CH(1)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .mode(mode0),
        .in_data(in_data0), .in_valid(in_valid0), .in_ready(in_ready0),
        .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready0),
        .busy(busy0), .done(done0)
    );

    pool_stream_unit #(.DATA_W(32), .FM_W(2), .FM_H(2), .CH(2)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .mode(mode1),
        .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
        .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1),
        .busy(busy1), .done(done1)
    );

    // Reference 2x2 pooling of a 4x4 frame, raster order.
    function automatic void model(input frame_t p, input logic m, output exp_t e);
        logic eff_max;
`ifdef POOL_STREAM_MAX_EN
        eff_max = m;
`else
        eff_max = 1'b0 & m;
`endif
        for (int wr = 0; wr < 2; wr++) begin
            for (int wc = 0; wc < 2; wc++) begin
                longint a, b, c, d, s, mx;
                a = p[(2*wr)*4 + 2*wc];
                b = p[(2*wr)*4 + 2*wc + 1];
                c = p[(2*wr+1)*4 + 2*wc];
                d = p[(2*wr+1)*4 + 2*wc + 1];
                s = a + b + c + d;
                mx = a;
                if (b > mx) mx = b;
                if (c > mx) mx = c;
                if (d > mx) mx = d;
                e[wr*2 + wc] = eff_max ? int'(mx) : int'(s >>> 2);
            end
        end
    endfunction

    task automatic mon0();
        int e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid0 && out_ready0) begin
                vectors++;
                out_cnt0++;
                if (q0.size() == 0) begin
                    miscompares++;
                    $display("FAIL sb0_extra: out_data=%0d, expected no output", $signed(out_data0));
                end else begin
                    e = q0.pop_front();
                    if (out_data0 !== e) begin
                        miscompares++;
                        $display("FAIL sb0_data: out_data=%0d, expected %0d", $signed(out_data0), e);
                    end
                end
            end
        end
    endtask

    task automatic mon1();
        int e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid1 && out_ready1) begin
                vectors++;
                out_cnt1++;
                if (q1.size() == 0) begin
                    miscompares++;
                    $display("FAIL sb1_extra: out_data=%0d, expected no output", $signed(out_data1));
                end else begin
                    e = q1.pop_front();
                    if (out_data1 !== e) begin
                        miscompares++;
                        $display("FAIL sb1_data: out_data=%0d, expected %0d", $signed(out_data1), e);
                    end
                end
            end
        end
    endtask

    // Drives one frame into dut0; pushes exp_v[k] as the k-th window completes.
    task automatic drive_frame0(input logic m, input frame_t pix, input exp_t exp_v, input int n_pix,
                                input int stall_n, input bit gaps, input bit poke,
                                output bit ok_done, output bit stall_ok);
        int idx = 0;
        int k = 0;
        int cyc = 0;
        int stall_left = stall_n;
        bit stall_on = 1'b0;
        logic [31:0] ref_d = 32'd0;
        ok_done  = 1'b0;
        stall_ok = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b1; mode0 = m;
        @(posedge clk); #1;
        start0 = 1'b0; mode0 = ~m;
        while (idx < n_pix && cyc < 400) begin
            out_ready0 = 1'b1;
            if (stall_left > 0 && out_valid0) begin
                if (!stall_on) begin
                    stall_on = 1'b1;
                    ref_d = out_data0;
                end else if (out_data0 !== ref_d) begin
                    stall_ok = 1'b0;
                end
                out_ready0 = 1'b0;
                stall_left--;
            end else if (stall_on && stall_left > 0) begin
                stall_ok = 1'b0;
            end
            in_valid0 = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data0  = pix[idx];
            start0    = poke && (idx == 8);
            #1;
            if (stall_on && !out_ready0 && in_ready0) stall_ok = 1'b0;
            if (in_valid0 && in_ready0) begin
                if (((idx / 4) % 2 == 1) && ((idx % 4) % 2 == 1)) begin
                    q0.push_back(exp_v[k]);
                    k++;
                end
                idx++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid0 = 1'b0;
        start0    = 1'b0;
        if (idx < n_pix) begin
            vectors++;
            miscompares++;
            $display("FAIL drive0_timeout: accepted %0d pixels, expected %0d", idx, n_pix);
        end
        if (stall_n > 0 && !stall_on) stall_ok = 1'b0;
        if (n_pix == 16) begin
            for (int w = 0; w < 60 && !ok_done; w++) begin
                out_ready0 = 1'b1;
                #1;
                if (done0) ok_done = 1'b1;
                else begin
                    @(posedge clk); #1;
                end
            end
        end
    endtask

    task automatic check_frame_end0(input string name, input bit ok_done, input int exp_cnt);
        vectors++;
        if (!ok_done) begin miscompares++; $display("FAIL %s_done: done seen=%0d, expected 1", name, ok_done); end
        vectors++;
        if (out_cnt0 !== exp_cnt) begin miscompares++; $display("FAIL %s_count: outputs=%0d, expected %0d", name, out_cnt0, exp_cnt); end
        vectors++;
        if (q0.size() != 0) begin miscompares++; $display("FAIL %s_pending: %0d expected outputs never seen, expected 0", name, q0.size()); end
        @(posedge clk); #1;
        vectors++;
        if (done0 !== 1'b0 || busy0 !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_idle: done=%b busy=%b, expected 0 0", name, done0, busy0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (out_valid0 !== 1'b0 || out_data0 !== 32'd0) begin miscompares++; $display("FAIL reset_out0: valid=%b data=%0d, expected 0 0", out_valid0, out_data0); end
        vectors++;
        if (in_ready0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0) begin miscompares++; $display("FAIL reset_ctl0: in_ready=%b busy=%b done=%b, expected 0 0 0", in_ready0, busy0, done0); end
        vectors++;
        if (out_valid1 !== 1'b0 || out_data1 !== 32'd0) begin miscompares++; $display("FAIL reset_out1: valid=%b data=%0d, expected 0 0", out_valid1, out_data1); end
        vectors++;
        if (in_ready1 !== 1'b0 || busy1 !== 1'b0 || done1 !== 1'b0) begin miscompares++; $display("FAIL reset_ctl1: in_ready=%b busy=%b done=%b, expected 0 0 0", in_ready1, busy1, done1); end
        rst = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (in_ready0 !== 1'b0 || busy0 !== 1'b0) begin miscompares++; $display("FAIL idle_no_start: in_ready=%b busy=%b, expected 0 0", in_ready0, busy0); end
    endtask

    task automatic test_avg();
        frame_t ramp;
        exp_t e = '{2, 4, 10, 12};
        bit ok_done, stall_ok;
        for (int i = 0; i < 16; i++) ramp[i] = i;
        out_cnt0 = 0;
        drive_frame0(1'b0, ramp, e, 16, 0, 1'b0, 1'b0, ok_done, stall_ok);
        check_frame_end0("avg", ok_done, 4);
    endtask

    task automatic test_max();
        frame_t ramp;
`ifdef POOL_STREAM_MAX_EN
        exp_t e = '{5, 7, 13, 15};
`else
        exp_t e = '{2, 4, 10, 12};
`endif
        bit ok_done, stall_ok;
        for (int i = 0; i < 16; i++) ramp[i] = i;
        out_cnt0 = 0;
        drive_frame0(1'b1, ramp, e, 16, 0, 1'b0, 1'b0, ok_done, stall_ok);
        check_frame_end0("max", ok_done, 4);
    endtask

    task automatic test_negative();
        frame_t p = '{-1, -2, 7, 6,  -3, -4, -5, 9,  1, 1, -1, -1,  1, 1, -1, 0};
        exp_t e_avg = '{-3, 4, 1, -1};
`ifdef POOL_STREAM_MAX_EN
        exp_t e_max = '{-1, 9, 1, 0};
`else
        exp_t e_max = '{-3, 4, 1, -1};
`endif
        bit ok_done, stall_ok;
        out_cnt0 = 0;
        drive_frame0(1'b0, p, e_avg, 16, 0, 1'b0, 1'b0, ok_done, stall_ok);
        check_frame_end0("neg_avg", ok_done, 4);
        out_cnt0 = 0;
        drive_frame0(1'b1, p, e_max, 16, 0, 1'b1, 1'b0, ok_done, stall_ok);
        check_frame_end0("neg_max", ok_done, 4);
    endtask

    task automatic test_backpressure();
        frame_t ramp;
        exp_t e = '{2, 4, 10, 12};
        bit ok_done, stall_ok;
        for (int i = 0; i < 16; i++) ramp[i] = i;
        out_cnt0 = 0;
        drive_frame0(1'b0, ramp, e, 16, 10, 1'b0, 1'b0, ok_done, stall_ok);
        vectors++;
        if (!stall_ok) begin miscompares++; $display("FAIL stall_hold: stall behaviour ok=%0d, expected 1 (in_ready low, out_data held)", stall_ok); end
        check_frame_end0("stall", ok_done, 4);
    endtask

    task automatic test_channels();
        int d1 [8] = '{1, 10, 3, 30, 5, 50, 7, 70};
        int idx = 0;
        int cyc = 0;
        bit seen = 1'b0;
        out_cnt1 = 0;
        @(posedge clk); #1;
        start1 = 1'b1; mode1 = 1'b0;
        @(posedge clk); #1;
        start1 = 1'b0;
        while (idx < 8 && cyc < 100) begin
            in_valid1 = 1'b1;
            in_data1  = d1[idx];
            out_ready1 = 1'b1;
            #1;
            if (in_valid1 && in_ready1) begin
                if (idx == 6) q1.push_back(4);
                if (idx == 7) q1.push_back(40);
                idx++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid1 = 1'b0;
        for (int w = 0; w < 40 && !seen; w++) begin
            if (done1) seen = 1'b1;
            else begin @(posedge clk); #1; end
        end
        vectors++;
        if (!seen) begin miscompares++; $display("FAIL ch2_done: done seen=%0d, expected 1", seen); end
        vectors++;
        if (out_cnt1 !== 2 || q1.size() != 0) begin miscompares++; $display("FAIL ch2_count: outputs=%0d pending=%0d, expected 2 0", out_cnt1, q1.size()); end
    endtask

    task automatic test_back_to_back();
        frame_t p;
        exp_t e;
        bit ok_done, stall_ok;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 16; i++) p[i] = int'($urandom());
            model(p, 1'b0, e);
            out_cnt0 = 0;
            drive_frame0(1'b0, p, e, 16, 0, 1'b1, (f == 1), ok_done, stall_ok);
            check_frame_end0((f == 0) ? "b2b_a" : "b2b_busy_start", ok_done, 4);
        end
    endtask

    task automatic test_mid_reset();
        frame_t ramp;
        exp_t e = '{2, 4, 10, 12};
        bit ok_done, stall_ok;
        for (int i = 0; i < 16; i++) ramp[i] = i;
        drive_frame0(1'b0, ramp, e, 6, 0, 1'b0, 1'b0, ok_done, stall_ok);
        in_valid0 = 1'b0;
        out_ready0 = 1'b0;
        #1;
        vectors++;
        if (out_valid0 !== 1'b1 || busy0 !== 1'b1) begin miscompares++; $display("FAIL mid_pending: valid=%b busy=%b, expected 1 1", out_valid0, busy0); end
        rst = 1'b1;
        #1;
        vectors++;
        if (out_valid0 !== 1'b0 || out_data0 !== 32'd0 || busy0 !== 1'b0 || in_ready0 !== 1'b0 || done0 !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: valid=%b data=%0d busy=%b in_ready=%b done=%b, expected all 0",
                     out_valid0, out_data0, busy0, in_ready0, done0);
        end
        q0.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        out_cnt0 = 0;
        drive_frame0(1'b0, ramp, e, 16, 0, 1'b0, 1'b0, ok_done, stall_ok);
        check_frame_end0("after_reset", ok_done, 4);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start0 = 1'b0; mode0 = 1'b0; in_valid0 = 1'b0; in_data0 = 32'd0; out_ready0 = 1'b1;
        start1 = 1'b0; mode1 = 1'b0; in_valid1 = 1'b0; in_data1 = 32'd0; out_ready1 = 1'b1;
        fork
            mon0();
            mon1();
        join_none
        test_reset();
        test_avg();
        test_max();
        test_negative();
        test_backpressure();
        test_channels();
        test_back_to_back();
        test_mid_reset();
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pool_stream_unit.md
POOL_STREAM_UNIT -- requirements
Module: pool_stream_unit

Interface
REQ-001 Parameter DATA_W, 32, signed pixel width.
REQ-002 Parameter FM_W, 6, feature-map width in pixels (even, >=2).
REQ-003 Parameter FM_H, 6, feature-map height in pixels (even, >=2).
REQ-004 Parameter CH, 1, channels, interleaved per pixel (channel index fastest).
REQ-005 Port clk, input, 1, single clock, all logic on rising edge.
REQ-006 Port rst, input, 1, asynchronous active-high reset.
REQ-007 Port start, input, 1, single-cycle pulse that begins a frame.
REQ-008 Port mode, input, 1, 0=average, 1=max; sampled on accepted start.
REQ-009 Port in_data, input, DATA_W, signed pixel in raster order.
REQ-010 Port in_valid, input, 1, in_data valid.
REQ-011 Port in_ready, output, 1, block accepts in_data this cycle.
REQ-012 Port out_data, output, DATA_W, signed pooled result.
REQ-013 Port out_valid, output, 1, out_data valid.
REQ-014 Port out_ready, input, 1, consumer accepts out_data.
REQ-015 Port busy, output, 1, frame in progress.
REQ-016 Port done, output, 1, one-cycle pulse at frame end.

Function
REQ-017 FSM states IDLE, RUN, FLUSH, DONE; IDLE->RUN on start, RUN->FLUSH on acceptance of last input pixel, FLUSH->DONE when the last output is accepted, DONE->IDLE after one cycle.
REQ-018 An input transfer occurs when in_valid and in_ready are both high; an output transfer occurs when out_valid and out_ready are both high.
REQ-019 in_ready is high only in RUN and only when the output register is empty or is being drained this cycle.
REQ-020 Window is 2x2, stride 2, no padding; output count per frame = (FM_W/2)*(FM_H/2)*CH, in raster order, channel fastest.
REQ-021 Even-row pixels are stored in a line buffer of FM_W*CH entries; odd-row, even-column pixels are held in CH registers.
REQ-022 On acceptance of the odd-row, odd-column pixel of channel c, the window result is written to the output register; out_valid rises on the next cycle.
REQ-023 Average: sum the four pixels at DATA_W+2 bits signed, arithmetic shift right by 2 (rounding toward minus infinity), result truncated to DATA_W.
REQ-024 Max: signed maximum of the four pixels.
REQ-025 out_data and out_valid are held stable until an output transfer occurs.
REQ-026 start while busy is ignored; mode is held constant for the whole frame.
REQ-027 done pulses in DONE; busy is high in RUN and FLUSH.
REQ-028 Column, row and channel counters wrap to 0 at end of frame; no input is accepted after the last pixel until the next start.
REQ-029 A frame with FM_W or FM_H odd, or either less than 2, is an elaboration error.

Reset
REQ-030 rst asynchronously forces IDLE and clears all counters and held registers; out_valid=0, out_data=0, in_ready=0, busy=0, done=0.
REQ-031 rst mid-frame discards all partial windows and any pending output; the next frame starts cleanly after a new start.

Configuration
REQ-032 Macro POOL_STREAM_MAX_EN: defined -> max mode available per REQ-024; undefined -> comparator logic absent, mode ignored, average only.

Structure
REQ-033 Shared package holds the state enumeration and the mode encodings (POOL_AVG=0, POOL_MAX=1).
REQ-034 One sub-module, pool_window_reduce: combinational 4-input reduce (average/max) selected by mode.

Verification
REQ-035 FM 4x4, CH=1, avg, pixels 0..15 -> outputs 2, 4, 10, 12, then done.
REQ-036 Same stimulus with max (macro defined) -> outputs 5, 7, 13, 15; macro undefined -> 2, 4, 10, 12.
REQ-037 Window {-1,-2,-3,-4}, avg -> -3 (floor of -2.5); max -> -1.
REQ-038 out_ready held low 10 cycles after the first output -> in_ready low, out_data stable, no output lost, 4 outputs total.
REQ-039 CH=2, FM 2x2, inputs (c0,c1) = (1,10),(3,30),(5,50),(7,70) -> outputs 4, 40.
REQ-040 rst asserted mid-frame after 6 inputs -> all outputs zero immediately; a new 4x4 frame gives the REQ-035 results.
